// File: rtl/camera_blob_pkg.sv
// Shared definitions for the camera blob writer: FSM states, result-block word offsets,
// status word layout and burst length.
// Optional bounding-box words are enabled by defining CAMERA_BLOB_BBOX_EN.
package camera_blob_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrSx,
        StWrSy,
        StWrCnt,
        StWrBb0,
        StWrBb1,
        StWrStat
    } state_e;

    // Byte offsets from the result block base address
    localparam logic [31:0] OFF_SX  = 32'd0;
    localparam logic [31:0] OFF_SY  = 32'd4;
    localparam logic [31:0] OFF_CNT = 32'd8;
    localparam logic [31:0] OFF_BB0 = 32'd12;
    localparam logic [31:0] OFF_BB1 = 32'd16;
`ifdef CAMERA_BLOB_BBOX_EN
    localparam logic [31:0] OFF_STAT  = 32'd20;
    localparam int unsigned BURST_LEN = 6;
`else
    localparam logic [31:0] OFF_STAT  = 32'd12;
    localparam int unsigned BURST_LEN = 4;
`endif

    // Status word field positions
    localparam int unsigned STAT_FOUND_BIT = 0;
    localparam int unsigned STAT_FCNT_LSB  = 8;
    localparam int unsigned STAT_OVR_LSB   = 24;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [31:0] pack_status(input logic [7:0]  overrun,
                                                input logic [15:0] frame_cnt,
                                                input logic        found);
        logic [31:0] w;
        w = '0;
        w[STAT_OVR_LSB +: 8]   = overrun;
        w[STAT_FCNT_LSB +: 16] = frame_cnt;
        w[STAT_FOUND_BIT]      = found;
        return w;
    endfunction

endpackage

// File: rtl/camera_blob_writer_if.sv
// Pixel stream in, shared-memory host write port out.
// master: the blob writer; slave: the pixel source / memory side.
interface camera_blob_writer_if;
    logic        pix_valid;
    logic [7:0]  pix_luma;
    logic        line_end;
    logic        frame_start;
    logic        frame_end;
    logic [31:0] camera_addr;
    logic [31:0] camera_dout;
    logic        camera_mwe;
    logic        busy;

    modport master (
        input  pix_valid, pix_luma, line_end, frame_start, frame_end,
        output camera_addr, camera_dout, camera_mwe, busy
    );

    modport slave (
        output pix_valid, pix_luma, line_end, frame_start, frame_end,
        input  camera_addr, camera_dout, camera_mwe, busy
    );
endinterface

// File: rtl/blob_accumulator.sv
// Per-frame centroid moment accumulator: x/y position counters, threshold compare,
// saturating sums and pixel count, optional bounding box (CAMERA_BLOB_BBOX_EN).
// Outputs are the values including this cycle's pixel but before any frame_start clear,
// so a coincident frame_end snapshot sees the complete frame.
module blob_accumulator
    import camera_blob_pkg::*;
#(
    parameter logic [7:0]  THRESH = 8'hC0,
    parameter int unsigned X_W    = 10,
    parameter int unsigned Y_W    = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_valid,
    input  logic [7:0]  pix_luma,
    input  logic        line_end,
    input  logic        frame_start,
    output logic [31:0] sum_x,
    output logic [31:0] sum_y,
    output logic [31:0] count
`ifdef CAMERA_BLOB_BBOX_EN
    ,
    output logic [31:0] bbox0,
    output logic [31:0] bbox1
`endif
);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [31:0]    sx_q, sx_d, sx_upd;
    logic [31:0]    sy_q, sy_d, sy_upd;
    logic [31:0]    cnt_q, cnt_d, cnt_upd;
    logic           hit;

    assign hit = pix_valid && (pix_luma >= THRESH);

    // Pixel update first, then line_end, then frame_start has the final word
    always_comb begin
        sx_upd  = hit ? sat_add32(sx_q, 32'(x_q)) : sx_q;
        sy_upd  = hit ? sat_add32(sy_q, 32'(y_q)) : sy_q;
        cnt_upd = hit ? sat_add32(cnt_q, 32'd1) : cnt_q;
        sx_d    = frame_start ? '0 : sx_upd;
        sy_d    = frame_start ? '0 : sy_upd;
        cnt_d   = frame_start ? '0 : cnt_upd;

        x_d = x_q;
        if (pix_valid && (x_q != '1)) x_d = x_q + 1'b1;
        if (line_end)                 x_d = '0;
        if (frame_start)              x_d = '0;

        y_d = y_q;
        if (line_end && (y_q != '1)) y_d = y_q + 1'b1;
        if (frame_start)             y_d = '0;
    end

    // Position counters and moment accumulators
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q   <= '0;
            y_q   <= '0;
            sx_q  <= '0;
            sy_q  <= '0;
            cnt_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            sx_q  <= sx_d;
            sy_q  <= sy_d;
            cnt_q <= cnt_d;
        end
    end

    assign sum_x = sx_upd;
    assign sum_y = sy_upd;
    assign count = cnt_upd;

`ifdef CAMERA_BLOB_BBOX_EN
    logic [X_W-1:0] min_x_q, min_x_upd, max_x_q, max_x_upd;
    logic [Y_W-1:0] min_y_q, min_y_upd, max_y_q, max_y_upd;

    // Bounding box of ball pixels; an empty frame reads min=all-ones, max=0
    always_comb begin
        min_x_upd = (hit && (x_q < min_x_q)) ? x_q : min_x_q;
        max_x_upd = (hit && (x_q > max_x_q)) ? x_q : max_x_q;
        min_y_upd = (hit && (y_q < min_y_q)) ? y_q : min_y_q;
        max_y_upd = (hit && (y_q > max_y_q)) ? y_q : max_y_q;
    end

    // Bounding box registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_x_q <= '1;
            max_x_q <= '0;
            min_y_q <= '1;
            max_y_q <= '0;
        end else if (frame_start) begin
            min_x_q <= '1;
            max_x_q <= '0;
            min_y_q <= '1;
            max_y_q <= '0;
        end else begin
            min_x_q <= min_x_upd;
            max_x_q <= max_x_upd;
            min_y_q <= min_y_upd;
            max_y_q <= max_y_upd;
        end
    end

    assign bbox0 = {16'(min_y_upd), 16'(min_x_upd)};
    assign bbox1 = {16'(max_y_upd), 16'(max_x_upd)};
`endif

endmodule

// File: rtl/camera_blob_writer.sv
// Camera-to-physics shared memory writer: accumulates ball centroid moments per frame
// and at frame_end writes them as a burst of single-cycle host writes, status last.
// Define CAMERA_BLOB_BBOX_EN to add two bounding-box words before the status word.
module camera_blob_writer
    import camera_blob_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  THRESH    = 8'hC0,
    parameter int unsigned X_W       = 10,
    parameter int unsigned Y_W       = 9
) (
    input logic                  clk,
    input logic                  reset_n,
    camera_blob_writer_if.master bus
);

    state_e      state_q, state_d;
    logic [31:0] acc_sx, acc_sy, acc_cnt;
    logic [31:0] sx_sh_q, sy_sh_q, cnt_sh_q;
    logic [15:0] frame_cnt_q;
    logic [7:0]  overrun_q;
    logic        accept, drop;

    assign accept = bus.frame_end && (state_q == StIdle);
    assign drop   = bus.frame_end && (state_q != StIdle);

`ifdef CAMERA_BLOB_BBOX_EN
    logic [31:0] acc_bb0, acc_bb1, bb0_sh_q, bb1_sh_q;
`endif

    blob_accumulator #(
        .THRESH (THRESH),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_acc (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_valid   (bus.pix_valid),
        .pix_luma    (bus.pix_luma),
        .line_end    (bus.line_end),
        .frame_start (bus.frame_start),
        .sum_x       (acc_sx),
        .sum_y       (acc_sy),
        .count       (acc_cnt)
`ifdef CAMERA_BLOB_BBOX_EN
        ,
        .bbox0       (acc_bb0),
        .bbox1       (acc_bb1)
`endif
    );

    // State, shadow snapshot and frame/overrun counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            sx_sh_q     <= '0;
            sy_sh_q     <= '0;
            cnt_sh_q    <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= '0;
`ifdef CAMERA_BLOB_BBOX_EN
            bb0_sh_q    <= '0;
            bb1_sh_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                sx_sh_q     <= acc_sx;
                sy_sh_q     <= acc_sy;
                cnt_sh_q    <= acc_cnt;
                frame_cnt_q <= frame_cnt_q + 16'd1;
`ifdef CAMERA_BLOB_BBOX_EN
                bb0_sh_q    <= acc_bb0;
                bb1_sh_q    <= acc_bb1;
`endif
            end
            if (drop && (overrun_q != 8'hFF)) overrun_q <= overrun_q + 8'd1;
        end
    end

    // Burst sequencing and host port drive; status carries the live overrun count
    always_comb begin
        state_d         = state_q;
        bus.camera_mwe  = 1'b0;
        bus.camera_addr = BASE_ADDR;
        bus.camera_dout = '0;
        bus.busy        = (state_q != StIdle);
        case (state_q)
            StIdle: begin
                if (bus.frame_end) state_d = StWrSx;
            end
            StWrSx: begin
                bus.camera_mwe  = 1'b1;
                bus.camera_addr = BASE_ADDR + OFF_SX;
                bus.camera_dout = sx_sh_q;
                state_d         = StWrSy;
            end
            StWrSy: begin
                bus.camera_mwe  = 1'b1;
                bus.camera_addr = BASE_ADDR + OFF_SY;
                bus.camera_dout = sy_sh_q;
                state_d         = StWrCnt;
            end
            StWrCnt: begin
                bus.camera_mwe  = 1'b1;
                bus.camera_addr = BASE_ADDR + OFF_CNT;
                bus.camera_dout = cnt_sh_q;
`ifdef CAMERA_BLOB_BBOX_EN
                state_d         = StWrBb0;
`else
                state_d         = StWrStat;
`endif
            end
`ifdef CAMERA_BLOB_BBOX_EN
            StWrBb0: begin
                bus.camera_mwe  = 1'b1;
                bus.camera_addr = BASE_ADDR + OFF_BB0;
                bus.camera_dout = bb0_sh_q;
                state_d         = StWrBb1;
            end
            StWrBb1: begin
                bus.camera_mwe  = 1'b1;
                bus.camera_addr = BASE_ADDR + OFF_BB1;
                bus.camera_dout = bb1_sh_q;
                state_d         = StWrStat;
            end
`endif
            StWrStat: begin
                bus.camera_mwe  = 1'b1;
                bus.camera_addr = BASE_ADDR + OFF_STAT;
                bus.camera_dout = pack_status(overrun_q, frame_cnt_q, cnt_sh_q != 32'd0);
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
